branch_predictor: RTL
=====================

# branch_predictor

Fetch-stage dynamic branch predictor: a direct-mapped BTB plus a 2-bit-saturating-counter PHT. It takes the fetch PC and returns a registered prediction (taken, target, BTB hit, current PHT state) aligned with the fetched instruction one cycle later. The prediction travels down the pipe to the branch resolution stage. That stage returns the PHT and BTB update buses consumed here.

## Interface
Parameters:
- PHT_IDX_W, 10, PHT index width; index = pc[12:3], 1024 entries
- BTB_ADDR_W, 7, BTB index width; index = pc[6:0], 128 entries
- BTB_TAG_W, 22, BTB tag width; tag = pc[28:7]
- PHT_INIT, 2'b01, PHT reset state (WEAK_NOT_TAKEN)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- lookup_valid_i  in  1  fetch PC valid this cycle
- lookup_pc_i  in  32  fetch PC
- stall_i  in  1  fetch stalled; hold prediction outputs
- flush_i  in  1  redirect; kill the registered prediction
- pht_wbus_i  in  13  [12] we, [11:2] index, [1:0] next state
- btb_wbus_i  in  63  [62] we, [61] valid, [60:54] addr, [53:32] tag, [31:0] target
- predict_valid_o  out  1  prediction outputs valid
- predict_pc_o  out  32  PC the prediction belongs to
- predict_taken_o  out  1  btb_hit & PHT state[1]
- predict_target_o  out  32  BTB target if predict_taken, else pc+4
- btb_hit_o  out  1  BTB entry valid and tag equal
- pht_curr_state_o  out  2  PHT counter read for this PC

## Operation
- PHT state encoding: 00 STRONG_NOT_TAKEN, 01 WEAK_NOT_TAKEN, 10 WEAK_TAKEN, 11 STRONG_TAKEN. The predictor stores the state supplied on pht_wbus_i verbatim. It performs no counter arithmetic of its own.
- BTB entry: {valid, tag[21:0], target[31:0]}. The predictor stores the fields supplied on btb_wbus_i verbatim. A write with valid=0 invalidates the entry.
- Lookup is combinational from lookup_pc_i:
  - hit = entry[pc[6:0]].valid & (entry.tag == pc[28:7])
  - state = pht[pc[12:3]]
  - taken = hit & state[1]
  - target = taken ? entry.target : pc + 32'd4, with 32-bit wrap
- Write-first bypass: if a PHT or BTB write targets the same index being looked up in the same cycle, the lookup uses the write data.
- Output register update, in priority order:
  1. flush_i: predict_valid_o <= 0. The other output registers are don't-care.
  2. stall_i: all outputs hold.
  3. Otherwise: predict_valid_o <= lookup_valid_i, and the remaining outputs load the lookup result.
- Table writes are independent of stall_i and flush_i. Any we=1 commits at the edge. PHT and BTB writes in the same cycle both commit.

## Timing
- Latency is 1 cycle: a PC presented at edge N produces outputs valid after edge N.
- A write at edge N is visible to a lookup in cycle N through the bypass, and to every later lookup through the tables.
- Reset (resetn=0) takes effect immediately, regardless of clk. Every valid bit and predict_valid_o is cleared. All other outputs go to 0. Every PHT entry is set to PHT_INIT.
- Reset asserted mid-operation discards any write in flight. The first lookup after reset release misses.
- Index aliasing is accepted behaviour:
  - PHT has no tag.
  - BTB conflicts replace the existing entry.

## Test plan
- After reset, lookup 0x1c000000 -> next cycle: predict_valid_o=1, btb_hit_o=0, pht_curr_state_o=01, predict_taken_o=0, predict_target_o=0x1c000004.
- Apply a BTB write (addr 0x10, tag pc[28:7] of 0x1c000010, target 0x1c000100, valid=1) and a PHT write (index 2, state 10), then look up 0x1c000010 -> btb_hit_o=1, pht_curr_state_o=10, predict_taken_o=1, predict_target_o=0x1c000100.
- Same tables as the previous test, look up 0x1c000090 (same BTB index, different tag) -> btb_hit_o=0, predict_taken_o=0, predict_target_o=0x1c000094.
- Present a PHT write (index 2, state 11) and a lookup of 0x1c000010 in the same cycle -> pht_curr_state_o=11 the next cycle (bypass).
- stall_i=1 for 3 cycles while lookup_pc_i changes -> outputs hold their values. Then flush_i=1 with stall_i=1 -> predict_valid_o=0 after that edge.
- Assert resetn=0 between edges during traffic -> predict_valid_o=0 immediately. After release, a lookup of the previously written 0x1c000010 -> btb_hit_o=0, pht_curr_state_o=01.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus a 2-bit PHT.
// The lookup is combinational from the fetch PC. The prediction is registered
// so that it lines up with the fetched instruction one cycle later.
// The PHT and BTB contents come from the resolution stage and are stored
// verbatim; this block does no counter arithmetic of its own.
module branch_predictor #(
  parameter int          PHT_IDX_W  = 10,
  parameter int          BTB_ADDR_W = 7,
  parameter int          BTB_TAG_W  = 22,
  parameter logic [1:0]  PHT_INIT   = 2'b01
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lookup_valid_i,
  input  logic [31:0] lookup_pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [12:0] pht_wbus_i,
  input  logic [62:0] btb_wbus_i,
  output logic        predict_valid_o,
  output logic [31:0] predict_pc_o,
  output logic        predict_taken_o,
  output logic [31:0] predict_target_o,
  output logic        btb_hit_o,
  output logic [1:0]  pht_curr_state_o
);

  localparam int PHT_ENTRIES = 1 << PHT_IDX_W;
  localparam int BTB_ENTRIES = 1 << BTB_ADDR_W;

  // write bus fields
  logic                  pht_we;
  logic [PHT_IDX_W-1:0]  pht_widx;
  logic [1:0]            pht_wstate;
  logic                  btb_we;
  logic                  btb_wvalid;
  logic [BTB_ADDR_W-1:0] btb_waddr;
  logic [BTB_TAG_W-1:0]  btb_wtag;
  logic [31:0]           btb_wtarget;

  assign pht_we      = pht_wbus_i[12];
  assign pht_widx    = pht_wbus_i[2 +: PHT_IDX_W];
  assign pht_wstate  = pht_wbus_i[1:0];
  assign btb_we      = btb_wbus_i[62];
  assign btb_wvalid  = btb_wbus_i[61];
  assign btb_waddr   = btb_wbus_i[32+BTB_TAG_W +: BTB_ADDR_W];
  assign btb_wtag    = btb_wbus_i[32 +: BTB_TAG_W];
  assign btb_wtarget = btb_wbus_i[31:0];

  // lookup indices
  logic [PHT_IDX_W-1:0]  lk_pht_idx;
  logic [BTB_ADDR_W-1:0] lk_btb_idx;
  logic [BTB_TAG_W-1:0]  lk_tag;

  assign lk_pht_idx = lookup_pc_i[3 +: PHT_IDX_W];
  assign lk_btb_idx = lookup_pc_i[0 +: BTB_ADDR_W];
  assign lk_tag     = lookup_pc_i[BTB_ADDR_W +: BTB_TAG_W];

  // tables
  logic [1:0]           pht_q       [PHT_ENTRIES];
  logic                 btb_valid_q [BTB_ENTRIES];
  logic [BTB_TAG_W-1:0] btb_tag_q   [BTB_ENTRIES];
  logic [31:0]          btb_tgt_q   [BTB_ENTRIES];

  // PHT counters: reset to PHT_INIT, otherwise take the resolved state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= PHT_INIT;
    end else if (pht_we) begin
      pht_q[pht_widx] <= pht_wstate;
    end
  end

  // BTB valid bits carry the reset; tag/target need no reset behind them
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
    end else if (btb_we) begin
      btb_valid_q[btb_waddr] <= btb_wvalid;
    end
  end

  // BTB payload storage
  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag_q[btb_waddr] <= btb_wtag;
      btb_tgt_q[btb_waddr] <= btb_wtarget;
    end
  end

  // combinational lookup with write-first bypass from the update buses
  logic                 rd_valid;
  logic [BTB_TAG_W-1:0] rd_tag;
  logic [31:0]          rd_tgt;
  logic [1:0]           rd_state;
  logic                 lk_hit;
  logic                 lk_taken;
  logic [31:0]          lk_target;

  always_comb begin
    rd_valid = btb_valid_q[lk_btb_idx];
    rd_tag   = btb_tag_q[lk_btb_idx];
    rd_tgt   = btb_tgt_q[lk_btb_idx];
    rd_state = pht_q[lk_pht_idx];
    if (btb_we && (btb_waddr == lk_btb_idx)) begin
      rd_valid = btb_wvalid;
      rd_tag   = btb_wtag;
      rd_tgt   = btb_wtarget;
    end
    if (pht_we && (pht_widx == lk_pht_idx)) begin
      rd_state = pht_wstate;
    end
    lk_hit    = rd_valid && (rd_tag == lk_tag);
    lk_taken  = lk_hit && rd_state[1];
    lk_target = lk_taken ? rd_tgt : (lookup_pc_i + 32'd4);
  end

  // output registers
  logic        valid_d,  valid_q;
  logic [31:0] pc_d,     pc_q;
  logic        taken_d,  taken_q;
  logic [31:0] target_d, target_q;
  logic        hit_d,    hit_q;
  logic [1:0]  state_d,  state_q;

  // flush kills the prediction, stall holds it, otherwise load the lookup
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    taken_d  = taken_q;
    target_d = target_q;
    hit_d    = hit_q;
    state_d  = state_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!stall_i) begin
      valid_d  = lookup_valid_i;
      pc_d     = lookup_pc_i;
      taken_d  = lk_taken;
      target_d = lk_target;
      hit_d    = lk_hit;
      state_d  = rd_state;
    end
  end

  // prediction register bank
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      hit_q    <= 1'b0;
      state_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      hit_q    <= hit_d;
      state_q  <= state_d;
    end
  end

  assign predict_valid_o  = valid_q;
  assign predict_pc_o     = pc_q;
  assign predict_taken_o  = taken_q;
  assign predict_target_o = target_q;
  assign btb_hit_o        = hit_q;
  assign pht_curr_state_o = state_q;

endmodule
